// File: rtl/mac_feeder_if.sv
// Bundle between mac_feeder and its memories, the downstream MAC and the result consumer.
// master = feeder side, slave = memories/MAC/consumer side.
interface mac_feeder_if #(
    parameter int unsigned IN_AW  = 4,
    parameter int unsigned W_AW   = 7,
    parameter int unsigned OUT_AW = 3
);
    logic [IN_AW-1:0]  in_addr;
    logic [15:0]       in_data;
    logic [W_AW-1:0]   w_addr;
    logic [15:0]       w_data;
    logic [15:0]       value;
    logic [15:0]       weight;
    logic              acc_clr_n;
    logic [15:0]       mac_out;
    logic              res_valid;
    logic              res_ready;
    logic [15:0]       res_data;
    logic [OUT_AW-1:0] res_idx;

    modport master (
        output in_addr, w_addr, value, weight, acc_clr_n, res_valid, res_data, res_idx,
        input  in_data, w_data, mac_out, res_ready
    );

    modport slave (
        input  in_addr, w_addr, value, weight, acc_clr_n, res_valid, res_data, res_idx,
        output in_data, w_data, mac_out, res_ready
    );
endinterface

// File: rtl/mac_feeder.sv
// Sequencer feeding value/weight pairs of one fully-connected layer into a Q8.8 MAC,
// capturing each neuron's result (optional ReLU) onto a valid/ready port.
module mac_feeder #(
    parameter int unsigned N_IN   = 16,
    parameter int unsigned N_OUT  = 8,
    parameter int unsigned IN_AW  = 4,
    parameter int unsigned W_AW   = 7,
    parameter int unsigned OUT_AW = 3,
    parameter bit          RELU   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    output logic         busy_o,
    output logic         done_o,
    mac_feeder_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_CAPTURE, S_WAIT
    } state_t;

    localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(N_OUT - 1);

    state_t            state_q;
    logic [IN_AW-1:0]  k_q;
    logic [OUT_AW-1:0] j_q;
    logic [1:0]        drain_q;
    logic [1:0]        pipe_q;
    logic [IN_AW-1:0]  in_addr_q;
    logic [W_AW-1:0]   w_addr_q;
    logic [15:0]       value_q;
    logic [15:0]       weight_q;
    logic [15:0]       res_data_q;
    logic [OUT_AW-1:0] res_idx_q;
    logic              res_valid_q;
    logic              done_q;

    logic [IN_AW-1:0]  k_d;
    logic [W_AW-1:0]   w_base_d;
    logic [15:0]       res_d;

    always_comb begin
        k_d      = k_q + IN_AW'(1);
        w_base_d = W_AW'(32'(j_q) * N_IN);
        res_d    = (RELU && bus.mac_out[15]) ? '0 : bus.mac_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            j_q         <= '0;
            drain_q     <= '0;
            pipe_q      <= '0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            value_q     <= '0;
            weight_q    <= '0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            // pipe_q[0]: address on the bus, pipe_q[1]: its data returning from memory
            pipe_q   <= {pipe_q[0], 1'b0};
            value_q  <= pipe_q[1] ? bus.in_data : '0;
            weight_q <= pipe_q[1] ? bus.w_data  : '0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        j_q     <= '0;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    k_q       <= '0;
                    in_addr_q <= '0;
                    w_addr_q  <= w_base_d;
                    pipe_q[0] <= 1'b1;
                    state_q   <= S_FETCH;
                end
                S_FETCH: begin
                    if (k_q == K_LAST) begin
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        k_q       <= k_d;
                        in_addr_q <= k_d;
                        w_addr_q  <= w_addr_q + W_AW'(1);
                        pipe_q[0] <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                    if (drain_q == 2'd2) state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    res_data_q  <= res_d;
                    res_idx_q   <= j_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (j_q == J_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            j_q     <= j_q + OUT_AW'(1);
                            state_q <= S_CLEAR;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign bus.acc_clr_n = !(state_q inside {S_IDLE, S_CLEAR});
    assign bus.in_addr   = in_addr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.value     = value_q;
    assign bus.weight    = weight_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench: two mac_feeder instances (RELU=1 and RELU=0) in lockstep on shared
// memories, each driving a small Q8.8 MAC model with a product stage and accumulator.
module tb_mac_feeder;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic res_ready;
    logic busy0, done0, busy1, done1;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int nz0 = 0;
    int nz1 = 0;
    int nz0_base, nz1_base;

    logic [15:0] in_mem [16];
    logic [15:0] w_mem  [128];

    logic signed [31:0] prod0, prod1;
    logic        [15:0] acc0, acc1;

    always #5 clk = ~clk;

    mac_feeder_if #(.IN_AW(4), .W_AW(7), .OUT_AW(3)) b0 ();
    mac_feeder_if #(.IN_AW(4), .W_AW(7), .OUT_AW(3)) b1 ();

    mac_feeder #(.N_IN(4), .N_OUT(3), .IN_AW(4), .W_AW(7), .OUT_AW(3), .RELU(1'b1)) u_relu (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy0), .done_o(done0), .bus(b0.master)
    );
    mac_feeder #(.N_IN(4), .N_OUT(3), .IN_AW(4), .W_AW(7), .OUT_AW(3), .RELU(1'b0)) u_lin (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy1), .done_o(done1), .bus(b1.master)
    );

    assign b0.res_ready = res_ready;
    assign b1.res_ready = res_ready;
    assign b0.mac_out   = acc0;
    assign b1.mac_out   = acc1;

    always_ff @(posedge clk) begin
        b0.in_data <= in_mem[b0.in_addr];
        b0.w_data  <= w_mem[b0.w_addr];
        b1.in_data <= in_mem[b1.in_addr];
        b1.w_data  <= w_mem[b1.w_addr];
    end

    // MAC: product registered, then accumulated as bits [23:8]; synchronous clear when acc_clr_n=0
    always_ff @(posedge clk) begin
        if (!b0.acc_clr_n) begin
            prod0 <= '0;
            acc0  <= '0;
        end else begin
            prod0 <= 32'(signed'(b0.value)) * 32'(signed'(b0.weight));
            acc0  <= acc0 + prod0[23:8];
        end
        if (!b1.acc_clr_n) begin
            prod1 <= '0;
            acc1  <= '0;
        end else begin
            prod1 <= 32'(signed'(b1.value)) * 32'(signed'(b1.weight));
            acc1  <= acc1 + prod1[23:8];
        end
    end

    always @(posedge clk) begin
        if (done0) done_cnt <= done_cnt + 1;
        if (b0.value != 16'h0 || b0.weight != 16'h0) nz0 <= nz0 + 1;
        if (b1.value != 16'h0 || b1.weight != 16'h0) nz1 <= nz1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs x = {1, 0.5, 2, -1}; neuron weights {0.5 x4}, {-0.5 x4}, {1, 2, 0.25, -3}
    task automatic load_distinct();
        for (int i = 0; i < 16; i++)  in_mem[i] = 16'h0000;
        for (int i = 0; i < 128; i++) w_mem[i]  = 16'h0000;
        in_mem[0] = 16'h0100; in_mem[1] = 16'h0080; in_mem[2] = 16'h0200; in_mem[3] = 16'hFF00;
        for (int i = 0; i < 4; i++) begin
            w_mem[i]     = 16'h0080;
            w_mem[4 + i] = 16'hFF80;
        end
        w_mem[8] = 16'h0100; w_mem[9] = 16'h0200; w_mem[10] = 16'h0040; w_mem[11] = 16'hFD00;
    endtask

    // Inputs all 1.0; weights 0.5, -0.5, 0.25 per neuron
    task automatic load_uniform();
        for (int i = 0; i < 4; i++) begin
            in_mem[i]    = 16'h0100;
            w_mem[i]     = 16'h0080;
            w_mem[4 + i] = 16'hFF80;
            w_mem[8 + i] = 16'h0040;
        end
    endtask

    task automatic kick_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nz0_base = nz0;
        nz1_base = nz1;
        check("start_busy", 32'(busy0), 1);
        check("start_clear", 32'(b0.acc_clr_n), 0);
    endtask

    // Waits for a result (bounded), checks both lanes, optionally stalls, then hands it off.
    task automatic get_result(input logic [15:0] exp_r, input logic [15:0] exp_l, input int idx,
                              input int stall, input int exp_lat);
        int n = 0;
        res_ready = (stall == 0);
        do begin
            @(negedge clk);
            n++;
        end while (!b0.res_valid && n < 200);
        check("res_valid", 32'(b0.res_valid), 1);
        check("res_valid_lin", 32'(b1.res_valid), 1);
        check("latency", n, exp_lat);
        check("res_data_relu", 32'(b0.res_data), 32'(exp_r));
        check("res_data_lin", 32'(b1.res_data), 32'(exp_l));
        check("res_idx", 32'(b0.res_idx), idx);
        check("res_idx_lin", 32'(b1.res_idx), idx);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(b0.res_valid), 1);
            check("stall_data", 32'(b1.res_data), 32'(exp_l));
            check("stall_idx", 32'(b0.res_idx), idx);
            check("stall_no_clear", 32'(b0.acc_clr_n), 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", 32'(b0.res_valid), 0);
    endtask

    initial begin
        int done_base;
        int n;
        rst = 1'b1;
        start = 1'b0;
        res_ready = 1'b1;
        load_distinct();
        repeat (3) @(negedge clk);
        check("rst_value", 32'(b0.value), 0);
        check("rst_weight", 32'(b0.weight), 0);
        check("rst_acc_clr_n", 32'(b0.acc_clr_n), 0);
        check("rst_res_valid", 32'(b0.res_valid), 0);
        check("rst_res_data", 32'(b0.res_data), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_in_addr", 32'(b0.in_addr), 0);
        check("rst_w_addr", 32'(b1.w_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Pass A: distinct weights, back-pressure on neuron 0, neuron 1 address sequence
        done_base = done_cnt;
        kick_start();
        get_result(16'h0140, 16'h0140, 0, 5, 9);
        check("n1_clear", 32'(b0.acc_clr_n), 0);
        check("n1_clear_busy", 32'(busy0), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("n1_in_addr", 32'(b0.in_addr), k);
            check("n1_w_addr", 32'(b0.w_addr), 4 + k);
        end
        get_result(16'h0000, 16'hFEC0, 1, 0, 5);
        get_result(16'h0580, 16'h0580, 2, 0, 9);
        check("A_done", 32'(done0), 1);
        check("A_done_lin", 32'(done1), 1);
        check("A_idle", 32'(busy0), 0);
        check("A_pairs", nz0 - nz0_base, 12);
        check("A_pairs_lin", nz1 - nz1_base, 12);
        @(negedge clk);
        check("A_done_count", done_cnt - done_base, 1);
        check("A_done_pulse", 32'(done0), 0);

        // Pass B: uniform data, minimum period, start accepted in the done cycle
        load_uniform();
        done_base = done_cnt;
        kick_start();
        get_result(16'h0200, 16'h0200, 0, 0, 9);
        get_result(16'h0000, 16'hFE00, 1, 0, 9);
        get_result(16'h0100, 16'h0100, 2, 0, 9);
        check("B_done", 32'(done0), 1);
        check("B_pairs", nz0 - nz0_base, 12);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("B_restart_busy", 32'(busy0), 1);
        check("B_restart_clear", 32'(b0.acc_clr_n), 0);
        check("B_done_count", done_cnt - done_base, 1);

        // Pass C: reset asserted at k=2 of neuron 0
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b0.in_addr == 4'd2 && b0.acc_clr_n && busy0) && n < 50);
        check("C_reach_k2", 32'(b0.in_addr), 2);
        done_base = done_cnt;
        rst = 1'b1;
        #1;
        check("C_rst_value", 32'(b0.value), 0);
        check("C_rst_weight", 32'(b1.weight), 0);
        check("C_rst_acc_clr_n", 32'(b0.acc_clr_n), 0);
        check("C_rst_res_data", 32'(b0.res_data), 0);
        check("C_rst_res_idx", 32'(b0.res_idx), 0);
        check("C_rst_busy", 32'(busy0), 0);
        check("C_rst_in_addr", 32'(b0.in_addr), 0);
        check("C_rst_w_addr", 32'(b0.w_addr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("C_no_done", done_cnt - done_base, 0);
        check("C_idle", 32'(busy0), 0);

        // Pass D: full pass after reset, with start pulsed while busy
        load_distinct();
        done_base = done_cnt;
        kick_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        get_result(16'h0140, 16'h0140, 0, 0, 7);
        get_result(16'h0000, 16'hFEC0, 1, 0, 9);
        get_result(16'h0580, 16'h0580, 2, 0, 9);
        check("D_done", 32'(done0), 1);
        check("D_pairs", nz0 - nz0_base, 12);
        repeat (20) @(negedge clk);
        check("D_idle", 32'(busy0), 0);
        check("D_single_done", done_cnt - done_base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
